// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY cycles,
// then performs a little-endian lane-merged store or an extended load on its internal RAM.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD   = CW'(LATENCY - 1);
  localparam logic [32:0]   ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] word_idx_s;
  logic [1:0]    lane_s;
  logic [31:0]   rd_word_s;
  logic [7:0]    byte_s;
  logic [15:0]   half_s;
  logic [31:0]   load_data_s;
  logic [31:0]   merged_s;
  logic          size_err_s;
  logic          range_err_s;
  logic          acc_err_s;
  logic          mem_we_s;

  assign word_idx_s  = addr_q[AW+1:2];
  assign lane_s      = addr_q[1:0];
  assign rd_word_s   = mem[word_idx_s];
  assign byte_s      = rd_word_s[{lane_s, 3'b000} +: 8];
  assign half_s      = addr_q[1] ? rd_word_s[31:16] : rd_word_s[15:0];
  assign range_err_s = ({1'b0, addr_q} >= ADDR_LIMIT);
  assign acc_err_s   = size_err_s | range_err_s;

  // Size/alignment legality of the captured request
  always_comb begin
    size_err_s = 1'b0;
    case (size_q)
      2'b00:   size_err_s = 1'b0;
      2'b01:   size_err_s = addr_q[0];
      2'b10:   size_err_s = (addr_q[1:0] != 2'b00);
      default: size_err_s = 1'b1;
    endcase
  end

  // Load extraction with sign or zero extension
  always_comb begin
    load_data_s = rd_word_s;
    case (size_q)
      2'b00:   load_data_s = uns_q ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
      2'b01:   load_data_s = uns_q ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
      default: load_data_s = rd_word_s;
    endcase
  end

  // Store lane merging; untouched lanes keep the current RAM word
  always_comb begin
    merged_s = rd_word_s;
    case (size_q)
      2'b00: merged_s[{lane_s, 3'b000} +: 8] = wdata_q[7:0];
      2'b01: begin
        if (addr_q[1]) begin
          merged_s[31:16] = wdata_q[15:0];
        end else begin
          merged_s[15:0] = wdata_q[15:0];
        end
      end
      2'b10:   merged_s = wdata_q;
      default: merged_s = rd_word_s;
    endcase
  end

  // Next-state and response computation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    mem_we_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          err_d        = acc_err_s;
          rdata_d      = (acc_err_s || we_q) ? 32'h00000000 : load_data_s;
          mem_we_s     = we_q && !acc_err_s;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // Control and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CW{1'b0}};
      we_q         <= 1'b0;
      addr_q       <= 32'h00000000;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      wdata_q      <= 32'h00000000;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'h00000000;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // RAM array; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[word_idx_s] <= merged_s;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder (memory) end of the multi-cycle CPU's data-memory request/response interface.
- Accepts one load or store at a time and inserts a configurable number of wait cycles.
- Stores perform little-endian byte-lane merging; loads perform byte-lane extraction with sign or zero extension (lb/lbu/lh/lhu/lw).
- Instantiated beside the multi-cycle datapath as its data memory model and bus endpoint.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the internal RAM (power of two)
LATENCY, 2, cycles from request acceptance to resp_valid (must be >= 1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  response present
resp_ready  input  1  requester accepts response
resp_rdata  output  32  load result (0 for stores and errors)
resp_err  output  1  misaligned, illegal-size or out-of-range access

Behaviour:
- States: IDLE, WAIT, RESP. Reset (rst = 0, asynchronous) forces IDLE, resp_valid = 0, resp_rdata = 0, resp_err = 0, wait counter = 0.
- req_ready = (state == IDLE), combinational from state. It is 1 immediately after reset release and 0 in WAIT and RESP.
- Accept on the rising edge with req_valid & req_ready:
  - Register all req_* fields.
  - Load counter with LATENCY-1.
  - Go to WAIT.
- WAIT: counter decrements each cycle. At the edge where the counter is 0:
  - Perform the access.
  - Register resp_rdata and resp_err.
  - Go to RESP.
  - resp_valid is high from edge E+LATENCY, where E is the accept edge.
- RESP: resp_valid = 1. resp_rdata and resp_err stay stable until the resp_valid & resp_ready edge, which returns to IDLE and clears resp_valid.
- Back-to-back: a new request is accepted no earlier than the cycle after the response handshake. Throughput is one transaction per LATENCY+2 cycles minimum.
- Error conditions (any one sets resp_err = 1):
  - req_size = 11.
  - Half access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
  - addr >= DEPTH_WORDS*4.
- On error: no RAM write, resp_rdata = 0.
- Word index is addr[log2(DEPTH_WORDS)+1:2]. Lane is addr[1:0], little-endian: lane 0 = bits 7:0.
- Store merging:
  - Byte: wdata[7:0] written into lane addr[1:0].
  - Half: wdata[15:0] written into bits 15:0 when addr[1] = 0, bits 31:16 when addr[1] = 1.
  - Word: full write.
  - Untouched lanes are preserved.
  - Stores return resp_rdata = 0, resp_err = 0.
- Load extraction:
  - The selected byte or half is right-aligned.
  - Upper bits are filled with the MSB of the extracted field when req_unsigned = 0, else with zeros.
  - Word loads ignore req_unsigned.
- Request inputs are ignored outside IDLE, including a req_valid held high during WAIT or RESP.
- Timing of RAM effects: the RAM is read and written only at the WAIT-to-RESP edge, so a load issued after a store observes the stored data.
- Reset mid-transaction:
  - Abandons the transaction.
  - A store reset before its WAIT-to-RESP edge does not modify RAM.
  - RAM contents are not cleared by reset; they are undefined until written.
- resp_ready may be held high permanently; the response then lasts exactly one cycle.

Test Plan:
- Word store then load, LATENCY=2:
  - Store addr 0x10, data 0xDEADBEEF, accepted at edge E; resp_valid from E+2 with resp_err = 0.
  - Load word addr 0x10; resp_rdata = 0xDEADBEEF.
- Byte and half extraction:
  - lb at 0x13 gives 0xFFFFFFDE; lbu at 0x13 gives 0x000000DE.
  - lh at 0x12 gives 0xFFFFDEAD; lhu at 0x10 gives 0x0000BEEF.
- Lane merge:
  - Store byte 0x55 at 0x11, then load word 0x10; result 0xDEAD55EF.
  - Store half 0x1234 at 0x12; word now 0x123455EF.
- Errors (each returns resp_err = 1, resp_rdata = 0, RAM unchanged on re-read):
  - Half load at 0x11.
  - Word store at 0x12.
  - req_size = 11.
  - Address 0x400 with DEPTH_WORDS = 256.
- Backpressure:
  - Hold resp_ready = 0 for 5 cycles in RESP; resp_valid, resp_rdata and resp_err remain stable and req_ready stays 0.
  - Raise resp_ready: IDLE on the next edge; the following request is accepted one cycle later.
- Reset mid-store: word store 0xCAFEF00D at 0x20, assert rst during WAIT.
  - Outputs clear asynchronously and req_ready = 1 after release.
  - Load 0x20 returns the prior contents, not 0xCAFEF00D.
